sdf_stage_ctrl: RTL

- Control sequencer for one radix-2^2 single-path delay-feedback (SDF) FFT stage.
- The stage's delay buffer (depth M/2) shifts on every clock with no enable.
- This block counts the input and output samples of each frame.
- It generates the butterfly/feed-through select, the delayed output-valid strobe, and the twiddle ROM address with its valid.
- It also detects frames that are broken by gaps in the input strobe.
- One instance sits beside each stage datapath in the FFT pipeline.

---
 rtl/sdf_stage_ctrl.sv | 76 +++++++
 1 files changed

// File: rtl/sdf_stage_ctrl.sv
// Control sequencer for one radix-2^2 SDF FFT stage: sample counters, butterfly select,
// delayed output strobe, twiddle ROM address/valid, and sticky frame-gap detection.
module sdf_stage_ctrl #(
   parameter int N     = 64,
   parameter int M     = 64,
   parameter int LOG_N = 6,
   parameter int LOG_M = 6
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             di_en,
   output logic             bf_sel,
   output logic             bf_out_en,
   output logic             tw_en,
   output logic [LOG_N-1:0] tw_addr,
   output logic             di_last,
   output logic             do_last,
   output logic             err
);

   localparam int               HALF   = M / 2;
   localparam int               SCALE  = LOG_N - LOG_M;
   localparam logic [LOG_N-1:0] LAST   = LOG_N'(N - 1);
   localparam logic [LOG_N-1:0] K_MASK = LOG_N'(M / 4 - 1);
   localparam logic [LOG_N-1:0] ONE    = LOG_N'(1);

   logic [LOG_N-1:0] di_count;
   logic [LOG_N-1:0] do_count;
   logic [HALF-1:0]  dly;
   logic [1:0]       seg;
   logic [LOG_N-1:0] t_val;
   logic [LOG_N-1:0] k_val;
   logic [LOG_N-1:0] tw_next;

   assign bf_out_en = dly[HALF-1];
   assign bf_sel    = di_en & di_count[LOG_M-1];
   assign di_last   = di_en & (di_count == LAST);
   assign do_last   = bf_out_en & (do_count == LAST);

   // Quarter-span index is bit-reversed to give the twiddle exponent multiplier.
   assign seg     = do_count[LOG_M-1 -: 2];
   assign t_val   = LOG_N'({seg[0], seg[1]});
   assign k_val   = do_count & K_MASK;
   assign tw_next = (t_val * k_val) << SCALE;

   always_ff @(posedge clock) begin
      if (reset) begin
         di_count <= '0;
         do_count <= '0;
         dly      <= '0;
         tw_en    <= 1'b0;
         tw_addr  <= '0;
         err      <= 1'b0;
      end else begin
         if (di_en) begin
            di_count <= di_count + ONE;
         end else if (di_count != '0) begin
            di_count <= '0;
            err      <= 1'b1;
         end

         // Free-running, like the datapath delay line it shadows.
         dly <= {dly[HALF-2:0], di_en};

         if (bf_out_en) begin
            do_count <= do_count + ONE;
         end else if (do_count != '0) begin
            do_count <= '0;
         end

         tw_en   <= bf_out_en;
         tw_addr <= bf_out_en ? tw_next : '0;
      end
   end

endmodule
